// File: rtl/ascon_round_ctrl.sv
// Round-index sequencer for the Ascon permutation: runs p^12 or p^6 (and p^8 when
// ASCON_P8_EN is defined) with a start/done handshake and a hold stall.
module ascon_round_ctrl #(
    parameter int NB_ROUNDS_A = 12,
    parameter int NB_ROUNDS_B = 6
) (
    input  logic       clock_i,
    input  logic       reset_i,
    input  logic       start_i,
    input  logic [1:0] mode_i,
    input  logic       hold_i,
    output logic [3:0] round_o,
    output logic       en_round_o,
    output logic       first_round_o,
    output logic       last_round_o,
    output logic       busy_o,
    output logic       done_o,
    output logic       err_o
);

    localparam logic [3:0] LAST_ROUND = 4'd11;
    localparam logic [3:0] START_A    = 4'(12 - NB_ROUNDS_A);
    localparam logic [3:0] START_B    = 4'(12 - NB_ROUNDS_B);
`ifdef ASCON_P8_EN
    localparam logic [3:0] START_P8   = 4'd4;
`endif

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] round_q, round_d;
    logic       first_q, first_d;
    logic       done_q, done_d;
    logic       err_q, err_d;
    logic       mode_legal;
    logic [3:0] start_index;

    // Mode decode: legality and the round index a call starts from.
    // NOTE: every signal assigned in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        mode_legal  = 1'b0;
        start_index = 4'd0;
        case (mode_i)
            2'b00: begin
                mode_legal  = 1'b1;
                start_index = START_A;
            end
            2'b10: begin
                mode_legal  = 1'b1;
                start_index = START_B;
            end
`ifdef ASCON_P8_EN
            2'b01: begin
                mode_legal  = 1'b1;
                start_index = START_P8;
            end
`endif
            default: ;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            round_q <= 4'd0;
            first_q <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            round_q <= round_d;
            first_q <= first_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    // Next state; the counter never wraps because reaching the last round leaves RUN.
    always_comb begin
        state_d = state_q;
        round_d = round_q;
        first_d = first_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    if (mode_legal) begin
                        state_d = RUN;
                        round_d = start_index;
                        first_d = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            RUN: begin
                if (!hold_i) begin
                    first_d = 1'b0;
                    if (round_q == LAST_ROUND) begin
                        state_d = IDLE;
                        round_d = 4'd0;
                        done_d  = 1'b1;
                    end else begin
                        round_d = round_q + 4'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs toward the permutation datapath.
    always_comb begin
        busy_o        = (state_q == RUN);
        en_round_o    = busy_o & ~hold_i;
        first_round_o = busy_o & first_q & ~hold_i;
        last_round_o  = busy_o & (round_q == LAST_ROUND);
        round_o       = round_q;
        done_o        = done_q;
        err_o         = err_q;
    end

endmodule
